serial_addsub_core: RTL and testbench

Parametrised multi-cycle serial adder/subtractor. It captures two WIDTH-bit operands on a start strobe and processes DIGIT bits per clock through a registered carry. It returns Sum, Cout and a signed-overflow flag with a one-cycle done pulse. It is the sequential successor to the team's combinational 32-bit serial adder and trades latency for area in datapaths that need occasional wide arithmetic.

---
 rtl/serial_addsub_core.sv | 95 +++++++++
 tb/tb_serial_addsub_core.sv | 138 +++++++++++++
 2 files changed

// File: rtl/serial_addsub_core.sv
// Multi-cycle serial adder/subtractor: DIGIT bits per clock through a registered carry.
// Subtraction is A + ~B + ~Cin, so Cout=1 means "no borrow".
module serial_addsub_core #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy,
  output logic             done,
  output logic             dbg_state_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, r_sr_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, ovf_q, done_q;

  logic [DIGIT:0]   s_d;
  logic [WIDTH-1:0] r_sr_d;
  logic             c_msb_in_d;
  logic             last_d;

  always_comb begin
    s_d        = {1'b0, a_sr_q[DIGIT-1:0]} + {1'b0, b_sr_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    r_sr_d     = WIDTH'({s_d[DIGIT-1:0], r_sr_q} >> DIGIT);
    // Carry into the top bit of this digit, recovered from the sum bit and its operands.
    c_msb_in_d = s_d[DIGIT-1] ^ a_sr_q[DIGIT-1] ^ b_sr_q[DIGIT-1];
    last_d     = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= A;
            b_sr_q  <= sub ? ~B : B;
            c_q     <= Cin ^ sub;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sr_q <= a_sr_q >> DIGIT;
          b_sr_q <= b_sr_q >> DIGIT;
          r_sr_q <= r_sr_d;
          c_q    <= s_d[DIGIT];
          cnt_q  <= cnt_q + CW'(1);
          if (last_d) begin
            sum_q   <= r_sr_d;
            cout_q  <= s_d[DIGIT];
            ovf_q   <= c_msb_in_d ^ s_d[DIGIT];
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Sum         = sum_q;
  assign Cout        = cout_q;
  assign Ovf         = ovf_q;
  assign done        = done_q;
  assign busy        = (state_q == RUN);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_addsub_core.sv
// Directed bench for serial_addsub_core: a DIGIT=1 and a DIGIT=4 instance, both 32 bits wide.
// Handshake: start is a one-cycle request taken in IDLE; done pulses once with the result.
module tb_serial_addsub_core;

  logic        clk, rst_n;
  logic        start1, start4, sub, cin;
  logic [31:0] a, b;
  logic [31:0] sum1, sum4;
  logic        cout1, ovf1, busy1, done1, st1;
  logic        cout4, ovf4, busy4, done4, st4;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

  serial_addsub_core #(.WIDTH(32), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .A(a), .B(b), .Cin(cin),
    .Sum(sum1), .Cout(cout1), .Ovf(ovf1), .busy(busy1), .done(done1), .dbg_state_o(st1)
  );

  serial_addsub_core #(.WIDTH(32), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .A(a), .B(b), .Cin(cin),
    .Sum(sum4), .Cout(cout4), .Ovf(ovf4), .busy(busy4), .done(done4), .dbg_state_o(st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen, with start low.
  task automatic run_op(input int inst, input logic [31:0] av, input logic [31:0] bv,
                        input logic cv, input logic sv, input logic [31:0] es,
                        input logic ec, input logic eo, input bit pulse_mid, input string tag);
    logic [33:0] exp;
    int lat, bcnt, n_exp;
    logic d, bz;
    n_exp = (inst == 1) ? 32 : 8;
    exp_q.push_back({eo, ec, es});
    a = av; b = bv; cin = cv; sub = sv;
    if (inst == 1) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    lat = 0; bcnt = 0;
    while (1) begin
      d  = (inst == 1) ? done1 : done4;
      bz = (inst == 1) ? busy1 : busy4;
      if (d || lat > 200) break;
      if (bz) bcnt++;
      if (pulse_mid && lat == 3) begin
        if (inst == 1) start1 = 1'b1; else start4 = 1'b1;
      end else begin
        start1 = 1'b0; start4 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start1 = 1'b0; start4 = 1'b0;
    check({tag, "_latency"}, lat, n_exp);
    check({tag, "_busy_cycles"}, bcnt, n_exp);
    check({tag, "_busy_in_done"}, (inst == 1) ? busy1 : busy4, 0);
    exp = exp_q.pop_front();
    check({tag, "_sum"},  (inst == 1) ? sum1  : sum4,  exp[31:0]);
    check({tag, "_cout"}, (inst == 1) ? cout1 : cout4, {31'b0, exp[32]});
    check({tag, "_ovf"},  (inst == 1) ? ovf1  : ovf4,  {31'b0, exp[33]});
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_sum1", sum1, 0);
    check("rst_cout1", cout1, 0);
    check("rst_ovf1", ovf1, 0);
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    check("rst_state1", st1, 0);
    check("rst_sum4", sum4, 0);
    check("rst_busy4", busy4, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1, 32'hABCD1234, 32'hDCBA4312, 1'b0, 1'b0, 32'h88875546, 1'b1, 1'b0, 1'b0, "add");
    run_op(1, 32'h1234ABCD, 32'h4321DCBA, 1'b1, 1'b0, 32'h55568888, 1'b0, 1'b0, 1'b0, "add_cin_b2b");
    @(negedge clk);
    check("done_pulse_width", done1, 0);
    check("sum_hold", sum1, 32'h55568888);
    run_op(1, 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, "sub");
    run_op(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, "ovf_add");
    run_op(1, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, "ovf_sub");

    @(negedge clk);
    run_op(4, 32'hABCD1234, 32'hDCBA4312, 1'b0, 1'b0, 32'h88875546, 1'b1, 1'b0, 1'b0, "d4_add");
    @(negedge clk);
    run_op(4, 32'hABCD1234, 32'hDCBA4312, 1'b0, 1'b0, 32'h88875546, 1'b1, 1'b0, 1'b1, "d4_midstart");
    @(negedge clk);
    check("d4_midstart_no_restart", busy4, 0);

    // abort a DIGIT=1 run at digit 10
    a = 32'hABCD1234; b = 32'hDCBA4312; cin = 1'b0; sub = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy1, 0);
    check("abort_sum", sum1, 0);
    check("abort_state", st1, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_sum_stays0", sum1, 0);
    run_op(1, 32'hABCD1234, 32'hDCBA4312, 1'b0, 1'b0, 32'h88875546, 1'b1, 1'b0, 1'b0, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
